// File: rtl/nano_ctrl_fsm.sv
// Multicycle control unit for the 8-bit Nano processor: fetches an instruction
// byte, decodes opcode[7:5] and sequences the datapath and memory handshake.
module nano_ctrl_fsm #(
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [2:0]       opcode,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             maddr_sel,
    output logic             raddr_sel,
    output logic             wb_sel,
    output logic             alu_sub,
    output logic             reg_we,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC     = 4'd3;
    localparam logic [3:0] S_IMM      = 4'd4;
    localparam logic [3:0] S_JZ_FETCH = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_HALT     = 4'd8;
    localparam logic [3:0] S_ERR      = 4'd9;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;

    localparam int WCW = $clog2(WAIT_MAX + 1);

    logic [3:0]     state, state_next;
    logic [WCW-1:0] wait_cnt;
    logic           in_mem;
    logic           retire;

    always_comb begin
        // NOTE: every output and helper gets a default first so no path leaves
        // a value held, which would otherwise infer a latch.
        state_next = state;
        in_mem     = 1'b0;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        maddr_sel  = 1'b0;
        raddr_sel  = 1'b0;
        wb_sel     = 1'b0;
        alu_sub    = 1'b0;
        reg_we     = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        halted     = 1'b0;
        bus_err    = 1'b0;

        case (state)
            S_IDLE: if (run) state_next = S_FETCH;
            S_FETCH: begin
                in_mem  = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP: begin retire = 1'b1; state_next = S_FETCH; end
                    OP_ADD, OP_SUB: state_next = S_EXEC;
                    OP_LDI: state_next = S_IMM;
                    OP_LD:  state_next = S_MEM_RD;
                    OP_ST:  state_next = S_MEM_WR;
                    OP_JZ:  state_next = S_JZ_FETCH;
                    default: begin retire = 1'b1; state_next = S_HALT; end
                endcase
            end
            S_EXEC: begin
                reg_we     = 1'b1;
                alu_sub    = (opcode == OP_SUB);
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_IMM: begin
                in_mem  = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    wb_sel     = 1'b1;
                    reg_we     = 1'b1;
                    pc_inc     = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_JZ_FETCH: begin
                in_mem  = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    pc_load    = zero_flag;
                    pc_inc     = !zero_flag;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEM_RD, S_MEM_WR: begin
                in_mem    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = (state == S_MEM_WR);
                maddr_sel = 1'b1;
                raddr_sel = 1'b1;
                if (mem_ready) begin
                    wb_sel     = (state == S_MEM_RD);
                    reg_we     = (state == S_MEM_RD);
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_HALT:  halted  = 1'b1;
            S_ERR:   bus_err = 1'b1;
            default: state_next = S_IDLE;
        endcase

        // mem_ready in the last permitted cycle wins over the timeout.
        if (in_mem && !mem_ready && wait_cnt == WCW'(WAIT_MAX - 1))
            state_next = S_ERR;
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state    <= state_next;
            // Every memory state is entered either from a non-memory state or
            // on a completion, so clearing on those cycles covers every entry.
            wait_cnt <= (in_mem && !mem_ready) ? wait_cnt + WCW'(1) : '0;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

endmodule
